// File: rtl/btb_update_controller.sv
// BTB write-port sequencer: round-robin EX/ID update arbitration, update FIFO, and flush sequencing.
// Optional statistics counters are built only when BTBC_STATS_EN is defined.
module btb_update_controller #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PC_WIDTH   = 32
) (
  input  logic                          btbc_clk,
  input  logic                          btbc_reset_n,
  input  logic                          btbc_ex_valid,
  input  logic [PC_WIDTH-1:0]           btbc_ex_pc,
  input  logic [PC_WIDTH-1:0]           btbc_ex_target,
  input  logic                          btbc_ex_taken,
  output logic                          btbc_ex_ready,
  input  logic                          btbc_id_valid,
  input  logic [PC_WIDTH-1:0]           btbc_id_pc,
  input  logic [PC_WIDTH-1:0]           btbc_id_target,
  output logic                          btbc_id_ready,
  input  logic                          btbc_flush_req,
  output logic                          btbc_flush_busy,
  output logic [$clog2(FIFO_DEPTH):0]   btbc_fifo_count,
  output logic                          btb_write,
  output logic [PC_WIDTH-1:0]           btb_new_pc,
  output logic [PC_WIDTH-1:0]           btb_data,
  output logic                          btb_branch_taken,
  output logic                          btb_reset,
  output logic [15:0]                   btbc_stat_writes,
  output logic [7:0]                    btbc_stat_flushes
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StFlush
  } state_e;

  state_e              state_q;
  logic                last_grant_id_q;
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [CntW-1:0]     count_q;

  logic [PC_WIDTH-1:0] pc_mem     [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] target_mem [FIFO_DEPTH];
  logic                taken_mem  [FIFO_DEPTH];

  logic                fifo_full;
  logic                fifo_empty;
  logic                can_push;
  logic                ex_win;
  logic                id_win;
  logic                push;
  logic                pop;
  logic [PC_WIDTH-1:0] push_pc;
  logic [PC_WIDTH-1:0] push_target;
  logic                push_taken;
  logic [CntW-1:0]     count_next;

  // Grant uses only state, occupancy, valids and last_grant, never the FIFO head.
  always_comb begin
    fifo_full   = (count_q == CntW'(FIFO_DEPTH));
    fifo_empty  = (count_q == '0);
    can_push    = (state_q == StRun) && !fifo_full;
    ex_win      = btbc_ex_valid && (!btbc_id_valid || last_grant_id_q);
    id_win      = btbc_id_valid && !ex_win;
    btbc_ex_ready = can_push && ex_win;
    btbc_id_ready = can_push && id_win;
    push        = btbc_ex_ready || btbc_id_ready;
    pop         = (state_q != StFlush) && !fifo_empty;
    push_pc     = btbc_ex_ready ? btbc_ex_pc     : btbc_id_pc;
    push_target = btbc_ex_ready ? btbc_ex_target : btbc_id_target;
    push_taken  = btbc_ex_ready ? btbc_ex_taken  : 1'b1;
    count_next  = count_q + CntW'(push) - CntW'(pop);
  end

  assign btbc_flush_busy = (state_q != StRun);
  assign btbc_fifo_count = count_q;

  // Payload storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge btbc_clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]     <= push_pc;
      target_mem[wr_ptr_q] <= push_target;
      taken_mem[wr_ptr_q]  <= push_taken;
    end
  end

  always_ff @(posedge btbc_clk or negedge btbc_reset_n) begin
    if (!btbc_reset_n) begin
      state_q          <= StRun;
      last_grant_id_q  <= 1'b1;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      btb_write        <= 1'b0;
      btb_new_pc       <= '0;
      btb_data         <= '0;
      btb_branch_taken <= 1'b0;
      btb_reset        <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_next;
      // Round-robin pointer only moves when both requesters contended.
      if (push && btbc_ex_valid && btbc_id_valid) last_grant_id_q <= btbc_id_ready;

      btb_write <= pop;
      if (pop) begin
        btb_new_pc       <= pc_mem[rd_ptr_q];
        btb_data         <= target_mem[rd_ptr_q];
        btb_branch_taken <= taken_mem[rd_ptr_q];
      end

      btb_reset <= 1'b0;
      case (state_q)
        StRun: begin
          if (btbc_flush_req) state_q <= StDrain;
        end
        StDrain: begin
          // Empty here means no pop this cycle, so the reset pulse cannot overlap a write.
          if (fifo_empty) begin
            state_q   <= StFlush;
            btb_reset <= 1'b1;
          end
        end
        StFlush: begin
          state_q <= StRun;
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

`ifdef BTBC_STATS_EN
  logic [15:0] stat_writes_q;
  logic [7:0]  stat_flushes_q;

  always_ff @(posedge btbc_clk or negedge btbc_reset_n) begin
    if (!btbc_reset_n) begin
      stat_writes_q  <= '0;
      stat_flushes_q <= '0;
    end else begin
      if (btb_write && (stat_writes_q != '1))  stat_writes_q  <= stat_writes_q + 16'd1;
      if (btb_reset && (stat_flushes_q != '1)) stat_flushes_q <= stat_flushes_q + 8'd1;
    end
  end

  assign btbc_stat_writes  = stat_writes_q;
  assign btbc_stat_flushes = stat_flushes_q;
`else
  assign btbc_stat_writes  = '0;
  assign btbc_stat_flushes = '0;
`endif

endmodule

// File: tb/tb_btb_update_controller.sv
// Scoreboard bench for btb_update_controller: stimulus pushes expected BTB writes, a monitor pops them.
module tb_btb_update_controller;

  localparam int unsigned Depth = 4;
  localparam int unsigned PcW   = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ex_valid, ex_taken, ex_ready;
  logic [PcW-1:0]   ex_pc, ex_target;
  logic             id_valid, id_ready;
  logic [PcW-1:0]   id_pc, id_target;
  logic             flush_req, flush_busy;
  logic [2:0]       fifo_count;
  logic             btb_write, btb_branch_taken, btb_reset;
  logic [PcW-1:0]   btb_new_pc, btb_data;
  logic [15:0]      stat_writes;
  logic [7:0]       stat_flushes;

  always #5 clk = ~clk;

  btb_update_controller #(
    .FIFO_DEPTH (Depth),
    .PC_WIDTH   (PcW)
  ) dut (
    .btbc_clk          (clk),
    .btbc_reset_n      (rst_n),
    .btbc_ex_valid     (ex_valid),
    .btbc_ex_pc        (ex_pc),
    .btbc_ex_target    (ex_target),
    .btbc_ex_taken     (ex_taken),
    .btbc_ex_ready     (ex_ready),
    .btbc_id_valid     (id_valid),
    .btbc_id_pc        (id_pc),
    .btbc_id_target    (id_target),
    .btbc_id_ready     (id_ready),
    .btbc_flush_req    (flush_req),
    .btbc_flush_busy   (flush_busy),
    .btbc_fifo_count   (fifo_count),
    .btb_write         (btb_write),
    .btb_new_pc        (btb_new_pc),
    .btb_data          (btb_data),
    .btb_branch_taken  (btb_branch_taken),
    .btb_reset         (btb_reset),
    .btbc_stat_writes  (stat_writes),
    .btbc_stat_flushes (stat_flushes)
  );

  typedef struct packed {
    logic [PcW-1:0] pc;
    logic [PcW-1:0] tgt;
    logic           tk;
  } upd_t;

  upd_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model: 0=RUN 1=DRAIN 2=FLUSH
  int   m_state;
  int   m_count;
  bit   m_last_id;
  bit   m_write;
  int   m_pops;
  int   m_flushes;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_count   = 0;
    m_last_id = 1'b1;
    m_write   = 1'b0;
    m_pops    = 0;
    m_flushes = 0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin : monitor
    upd_t e;
    if (rst_n === 1'b1 && btb_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(btb_new_pc), 64'hdead_beef);
      end else begin
        e = exp_q.pop_front();
        chk("write_pc", 64'(btb_new_pc), 64'(e.pc));
        chk("write_target", 64'(btb_data), 64'(e.tgt));
        chk("write_taken", 64'(btb_branch_taken), 64'(e.tk));
      end
      chk("write_with_reset", 64'(btb_reset), 64'd0);
    end
  end

  task automatic step(input bit exv, input logic [PcW-1:0] expc, input logic [PcW-1:0] extgt,
                      input bit extk, input bit idv, input logic [PcW-1:0] idpc,
                      input logic [PcW-1:0] idtgt, input bit fl);
    bit run, ex_win, id_win, exr, idr, pop;
    int cnt0;
    @(negedge clk);
    ex_valid = exv; ex_pc = expc; ex_target = extgt; ex_taken = extk;
    id_valid = idv; id_pc = idpc; id_target = idtgt; flush_req = fl;
    #1;
    run    = (m_state == 0);
    ex_win = exv && (!idv || m_last_id);
    id_win = idv && !ex_win;
    exr    = run && (m_count < Depth) && ex_win;
    idr    = run && (m_count < Depth) && id_win;
    chk("ex_ready", 64'(ex_ready), 64'(exr));
    chk("id_ready", 64'(id_ready), 64'(idr));
    chk("fifo_count", 64'(fifo_count), 64'(m_count));
    chk("flush_busy", 64'(flush_busy), 64'(m_state != 0));
    chk("btb_reset", 64'(btb_reset), 64'(m_state == 2));
    chk("btb_write", 64'(btb_write), 64'(m_write));
    if (exr) exp_q.push_back('{pc: expc, tgt: extgt, tk: extk});
    if (idr) exp_q.push_back('{pc: idpc, tgt: idtgt, tk: 1'b1});
    if (exv && idv && (exr || idr)) m_last_id = idr;
    pop  = (m_state != 2) && (m_count > 0);
    cnt0 = m_count;
    @(posedge clk);
    m_write = pop;
    if (pop) m_pops++;
    m_count = m_count + int'(exr || idr) - int'(pop);
    case (m_state)
      0: if (fl) m_state = 1;
      1: if (cnt0 == 0) m_state = 2;
      default: begin
        m_state = 0;
        m_flushes++;
      end
    endcase
  endtask

  task automatic idle(input int n, input bit fl);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, '0, '0, fl);
  endtask

  task automatic check_stats();
`ifdef BTBC_STATS_EN
    chk("stat_writes", 64'(stat_writes), 64'((m_pops > 65535) ? 65535 : m_pops));
    chk("stat_flushes", 64'(stat_flushes), 64'((m_flushes > 255) ? 255 : m_flushes));
`else
    chk("stat_writes", 64'(stat_writes), 64'd0);
    chk("stat_flushes", 64'(stat_flushes), 64'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_pc = '0; ex_target = '0; ex_taken = 0;
    id_valid = 0; id_pc = '0; id_target = '0; flush_req = 0;
    model_reset();
    #12;
    chk("rst_ex_ready", 64'(ex_ready), 64'd0);
    chk("rst_id_ready", 64'(id_ready), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_busy", 64'(flush_busy), 64'd0);
    chk("rst_write", 64'(btb_write), 64'd0);
    chk("rst_pc", 64'(btb_new_pc), 64'd0);
    chk("rst_data", 64'(btb_data), 64'd0);
    chk("rst_taken", 64'(btb_branch_taken), 64'd0);
    chk("rst_btb_reset", 64'(btb_reset), 64'd0);
    check_stats();
    @(negedge clk);
    rst_n = 1'b1;

    // Contention from reset: EX, ID, EX, ID
    for (int i = 0; i < 4; i++) step(1, 32'h10, 32'h1010, 0, 1, 32'h20, 32'h2020, 0);
    idle(2, 0);

    step(1, 32'h100, 32'h200, 1, 0, '0, '0, 0);
    idle(2, 0);

    // Backpressure with distinct payloads every cycle
    for (int i = 0; i < 8; i++)
      step(1, 32'h1000 + 32'(i), 32'h3000 + 32'(i), i[0], 1, 32'h2000 + 32'(i), 32'h4000 + 32'(i), 0);
    idle(3, 0);
    check_stats();

    // Flush after three updates; requesters keep asking during DRAIN/FLUSH
    step(1, 32'h700, 32'h800, 1, 0, '0, '0, 0);
    step(1, 32'h704, 32'h804, 0, 0, '0, '0, 0);
    step(0, '0, '0, 0, 1, 32'h708, 32'h808, 1);
    for (int i = 0; i < 4; i++) step(1, 32'h900, 32'h990, 1, 1, 32'ha00, 32'haa0, 0);
    idle(4, 0);
    check_stats();

    // Flush request held high: back-to-back flushes
    idle(7, 1);
    idle(4, 0);
    check_stats();

    // Async reset while in DRAIN with one entry still queued
    step(1, 32'h500, 32'h600, 1, 0, '0, '0, 1);
    @(negedge clk);
    ex_valid = 0; id_valid = 0; flush_req = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_busy", 64'(flush_busy), 64'd0);
    chk("mid_rst_count", 64'(fifo_count), 64'd0);
    chk("mid_rst_btb_reset", 64'(btb_reset), 64'd0);
    chk("mid_rst_write", 64'(btb_write), 64'd0);
    chk("mid_rst_ex_ready", 64'(ex_ready), 64'd0);
    check_stats();
    @(negedge clk);
    rst_n = 1'b1;
    idle(3, 0);
    step(1, 32'h5a0, 32'h6b0, 0, 0, '0, '0, 0);
    idle(3, 0);
    check_stats();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
